// File: rtl/dmem_arbiter_if.sv
// Request/response bus between the two data-memory requesters and dmem_arbiter.
// Port 0 is the load/store unit, port 1 the loader/debug master.
interface dmem_arbiter_if #(
  parameter int W = 8,
  parameter int A = 8
) ();
  logic [1:0]   ReqValid;
  logic [1:0]   ReqWrite;
  logic [A-1:0] ReqAddr0;
  logic [A-1:0] ReqAddr1;
  logic [W-1:0] ReqData0;
  logic [W-1:0] ReqData1;
  logic [1:0]   ReqReady;
  logic [1:0]   RspValid;
  logic [W-1:0] RspData0;
  logic [W-1:0] RspData1;

  modport master (
    output ReqValid, ReqWrite, ReqAddr0, ReqAddr1, ReqData0, ReqData1,
    input  ReqReady, RspValid, RspData0, RspData1
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr0, ReqAddr1, ReqData0, ReqData1,
    output ReqReady, RspValid, RspData0, RspData1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of a single-port data memory, with a
// sequencer that sweeps zeros through every address on ClearStart.
module dmem_arbiter #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          ClearStart,
  output logic          ClearBusy,
  output logic          ClearDone,
  dmem_arbiter_if.slave bus,
  output logic          MemWriteEn,
  output logic [A-1:0]  MemAddr,
  output logic [W-1:0]  MemDataIn,
  input  logic [W-1:0]  MemDataOut
);
  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [A-1:0] CountMax = {A{1'b1}};
  localparam logic [A-1:0] CountOne = {{(A-1){1'b0}}, 1'b1};

  state_t       state_r;
  state_t       state_nxt_s;
  logic         last_grant_r;
  logic [A-1:0] clear_count_r;
  logic         clear_done_r;
  logic [1:0]   rsp_valid_r;
  logic [W-1:0] rsp_data0_r;
  logic [W-1:0] rsp_data1_r;
  logic [1:0]   grant_s;
  logic         clear_last_s;

  assign clear_last_s = (clear_count_r == CountMax);

  // Next-state selection for the idle/clear sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ClearStart) state_nxt_s = CLEAR;
        else            state_nxt_s = IDLE;
      end
      CLEAR: begin
        if (clear_last_s) state_nxt_s = IDLE;
        else              state_nxt_s = CLEAR;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant selection; a pending clear blocks both ports, ties go to the port not served last
  always_comb begin
    grant_s = 2'b00;
    if ((state_r != IDLE) || ClearStart) begin
      grant_s = 2'b00;
    end else begin
      case (bus.ReqValid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end
  end

  // Memory port steering: clear sweep, granted requester, or quiet bus
  always_comb begin
    MemWriteEn = 1'b0;
    MemAddr    = {A{1'b0}};
    MemDataIn  = {W{1'b0}};
    if (state_r == CLEAR) begin
      MemWriteEn = 1'b1;
      MemAddr    = clear_count_r;
      MemDataIn  = {W{1'b0}};
    end else if (grant_s[0]) begin
      MemWriteEn = bus.ReqWrite[0];
      MemAddr    = bus.ReqAddr0;
      MemDataIn  = bus.ReqData0;
    end else if (grant_s[1]) begin
      MemWriteEn = bus.ReqWrite[1];
      MemAddr    = bus.ReqAddr1;
      MemDataIn  = bus.ReqData1;
    end else begin
      MemWriteEn = 1'b0;
    end
  end

  // Sequencer state, round-robin pointer and clear address counter
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r       <= IDLE;
      last_grant_r  <= 1'b1;
      clear_count_r <= {A{1'b0}};
      clear_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      clear_done_r <= (state_r == CLEAR) && clear_last_s;
      if (grant_s != 2'b00) begin
        last_grant_r <= grant_s[1];
      end
      // Natural wrap leaves the counter at zero when the sweep ends
      if (state_r == CLEAR) begin
        clear_count_r <= clear_count_r + CountOne;
      end
    end
  end

  // Read responses: capture memory data on a read handshake, pulse valid for one cycle
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rsp_valid_r <= 2'b00;
      rsp_data0_r <= {W{1'b0}};
      rsp_data1_r <= {W{1'b0}};
    end else begin
      rsp_valid_r <= grant_s & ~bus.ReqWrite;
      if (grant_s[0] && !bus.ReqWrite[0]) begin
        rsp_data0_r <= MemDataOut;
      end
      if (grant_s[1] && !bus.ReqWrite[1]) begin
        rsp_data1_r <= MemDataOut;
      end
    end
  end

  assign bus.ReqReady = grant_s;
  assign bus.RspValid = rsp_valid_r;
  assign bus.RspData0 = rsp_data0_r;
  assign bus.RspData1 = rsp_data1_r;
  assign ClearBusy    = (state_r == CLEAR);
  assign ClearDone    = clear_done_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a transaction-level model
// of the arbiter and a shadow copy of the memory contents.
module tb_dmem_arbiter;
  logic       Clk;
  logic       ResetN;
  logic       ClearStart;
  logic       ClearBusy;
  logic       ClearDone;
  logic       MemWriteEn;
  logic [7:0] MemAddr;
  logic [7:0] MemDataIn;
  logic [7:0] MemDataOut;

  dmem_arbiter_if #(.W(8), .A(8)) bus ();

  dmem_arbiter #(.W(8), .A(8)) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .ClearStart (ClearStart),
    .ClearBusy  (ClearBusy),
    .ClearDone  (ClearDone),
    .bus        (bus),
    .MemWriteEn (MemWriteEn),
    .MemAddr    (MemAddr),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Physical memory: combinational read, write on the rising edge
  logic [7:0] mem [256];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddr] <= MemDataIn;
  assign MemDataOut = mem[MemAddr];

  // Reference model state
  logic [7:0] exp_mem [256];
  bit         m_clearing;
  bit         m_done;
  int         m_idx;
  int         m_last;
  logic [1:0] m_rsp_v;
  logic [7:0] m_rsp_d [2];

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int busy_cnt;
  int done_cnt;
  logic [1:0] seen_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b0;
    m_done     = 1'b0;
    m_idx      = 0;
    m_last     = 1;
    m_rsp_v    = 2'b00;
    m_rsp_d[0] = 8'h00;
    m_rsp_d[1] = 8'h00;
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, input logic cs);
    int         g;
    logic [1:0] exp_rdy;
    logic       exp_we;
    logic [7:0] exp_addr;
    logic [7:0] exp_din;
    bus.ReqValid = v;   bus.ReqWrite = w;
    bus.ReqAddr0 = a0;  bus.ReqAddr1 = a1;
    bus.ReqData0 = d0;  bus.ReqData1 = d1;
    ClearStart   = cs;
    #1;
    if (m_clearing || cs)  g = -1;
    else if (v == 2'b11)   g = (m_last == 0) ? 1 : 0;
    else if (v == 2'b01)   g = 0;
    else if (v == 2'b10)   g = 1;
    else                   g = -1;
    exp_rdy  = (g < 0) ? 2'b00 : 2'(1 << g);
    exp_we   = m_clearing ? 1'b1 : ((g >= 0) ? w[g] : 1'b0);
    exp_addr = m_clearing ? 8'(m_idx) : ((g == 0) ? a0 : ((g == 1) ? a1 : 8'h00));
    exp_din  = m_clearing ? 8'h00 : ((g == 1) ? d1 : d0);
    seen_ready = bus.ReqReady;
    if (ClearBusy === 1'b1) busy_cnt++;
    if (ClearDone === 1'b1) done_cnt++;
    chk("req_ready", bus.ReqReady, exp_rdy);
    chk("mem_we", MemWriteEn, exp_we);
    chk("mem_addr", MemAddr, exp_addr);
    if (exp_we) chk("mem_din", MemDataIn, exp_din);
    @(posedge Clk);
    m_rsp_v = 2'b00;
    if (g >= 0) begin
      m_last = g;
      if (w[g]) exp_mem[exp_addr] = exp_din;
      else begin
        m_rsp_v[g] = 1'b1;
        m_rsp_d[g] = exp_mem[exp_addr];
      end
    end
    m_done = 1'b0;
    if (m_clearing) begin
      exp_mem[m_idx] = 8'h00;
      if (m_idx == 255) begin
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end
      m_idx = (m_idx + 1) % 256;
    end else if (cs) begin
      m_clearing = 1'b1;
      m_idx      = 0;
    end
    @(negedge Clk);
    chk("rsp_valid", bus.RspValid, m_rsp_v);
    chk("rsp_data0", bus.RspData0, m_rsp_d[0]);
    chk("rsp_data1", bus.RspData1, m_rsp_d[1]);
    chk("clear_busy", ClearBusy, m_clearing);
    chk("clear_done", ClearDone, m_done);
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, outputs checked before any clock edge
  task automatic pulse_reset();
    bus.ReqValid = 2'b00;
    ClearStart   = 1'b0;
    #2 ResetN = 1'b0;
    #1;
    chk("rst_busy", ClearBusy, 1'b0);
    chk("rst_done", ClearDone, 1'b0);
    chk("rst_rspv", bus.RspValid, 2'b00);
    chk("rst_rsp0", bus.RspData0, 8'h00);
    chk("rst_rsp1", bus.RspData1, 8'h00);
    chk("rst_we", MemWriteEn, 1'b0);
    model_reset();
    @(negedge Clk);
    ResetN = 1'b1;
  endtask

  initial begin
    ResetN = 1'b0;
    ClearStart = 1'b0;
    bus.ReqValid = 2'b00; bus.ReqWrite = 2'b00;
    bus.ReqAddr0 = 8'h00; bus.ReqAddr1 = 8'h00;
    bus.ReqData0 = 8'h00; bus.ReqData1 = 8'h00;
    model_reset();
    #1;
    chk("init_rspv", bus.RspValid, 2'b00);
    chk("init_rsp0", bus.RspData0, 8'h00);
    chk("init_busy", ClearBusy, 1'b0);
    chk("init_we", MemWriteEn, 1'b0);
    @(negedge Clk);
    ResetN = 1'b1;

    // Port 0 write then read-back
    step(2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 1'b0);
    chk("t1_nowrsp", bus.RspValid, 2'b00);
    step(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t1_rspv", bus.RspValid, 2'b01);
    chk("t1_rspd", bus.RspData0, 8'hA5);
    idle();
    chk("t1_rsp_once", bus.RspValid, 2'b00);

    // Preload every address through port 0 so the model knows the whole memory
    for (int i = 0; i < 256; i++)
      step(2'b01, 2'b01, 8'(i), 8'h00, 8'($urandom_range(1, 255)), 8'h00, 1'b0);

    // Round-robin alternation after reset
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0);
      chk("t2_grant", seen_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Port 1 write, port 0 reads it on the next cycle
    step(2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h3C, 1'b0);
    step(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t3_rspd", bus.RspData0, 8'h3C);

    // Full clear colliding with requests on both ports
    step(2'b01, 2'b01, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0);
    step(2'b10, 2'b10, 8'h00, 8'h7F, 8'h00, 8'h22, 1'b0);
    step(2'b01, 2'b01, 8'hFF, 8'h00, 8'h33, 8'h00, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    step(2'b11, 2'b00, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b1);
    chk("t4_nohs", seen_ready, 2'b00);
    for (int i = 0; i < 260; i++) step(2'b11, 2'b00, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b0);
    chk("t4_busy_len", busy_cnt, 256);
    chk("t4_done_cnt", done_cnt, 1);
    step(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4_rd00", bus.RspData0, 8'h00);
    step(2'b10, 2'b00, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b0);
    chk("t4_rd7f", bus.RspData1, 8'h00);
    step(2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4_rdff", bus.RspData0, 8'h00);

    // Reset during a clear sweep
    step(2'b01, 2'b01, 8'h40, 8'h00, 8'h77, 8'h00, 1'b0);
    step(2'b01, 2'b01, 8'h10, 8'h00, 8'h99, 8'h00, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) idle();
    pulse_reset();
    for (int i = 0; i < 3; i++) idle();
    chk("t5_nodone", done_cnt, 0);
    step(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t5_rd40", bus.RspData0, 8'h77);
    step(2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 1'b0);
    chk("t5_rd10", bus.RspData1, 8'h00);

    // Second ClearStart during a sweep is ignored
    busy_cnt = 0; done_cnt = 0;
    step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 260; i++)
      step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, (i == 99) ? 1'b1 : 1'b0);
    chk("t6_busy_len", busy_cnt, 256);
    chk("t6_done_cnt", done_cnt, 1);

    // Randomized traffic over a small address window to provoke read-after-write hits
    for (int i = 0; i < 600; i++)
      step(2'($urandom), 2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom), ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
